// File: rtl/uart_rx_responder.sv
// uart_rx_responder
//   Receive half of the memory-mapped UART. Deserialises 8N1 frames (8E1 when
//   UART_RX_PARITY_EN is defined) from rx, stores complete bytes in a FIFO and
//   serves CPU loads through uart_read_en / rd_data.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   rx           serial input, idle high, asynchronous to clk
//   uart_read_en CPU read strobe; pops one FIFO entry per asserted cycle
//   rd_data      {22'b0, overflow, rx_valid, head_byte}; head_byte is 0 when empty
//   rx_valid     FIFO not empty
//   overflow     sticky: a complete byte was dropped because the FIFO was full
//   frame_err    one-cycle pulse on a bad stop bit (or bad parity)
//
// Configuration macro
//   UART_RX_PARITY_EN  adds an even-parity bit after the data bits (8E1 framing)
module uart_rx_responder #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        uart_read_en,
  output logic [31:0] rd_data,
  output logic        rx_valid,
  output logic        overflow,
  output logic        frame_err
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW     = $clog2(FIFO_DEPTH + 1);

  localparam logic [CntW-1:0]   CntFull   = CntW'(ClksPerBit);
  localparam logic [CntW-1:0]   CntHalf   = CntW'(ClksPerBit / 2);
  localparam logic [CountW-1:0] CountFull = CountW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

  // Input synchroniser; resets to the idle line level so reset never looks like a start bit.
  logic rx_meta_q, rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  // Receive FSM
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            frame_err_q;
  logic            tick;
  logic            parity_ok;
  logic            push;

`ifdef UART_RX_PARITY_EN
  logic parity_q;
  assign parity_ok = ~(^{parity_q, shift_q});
`else
  assign parity_ok = 1'b1;
`endif

  // Sample point: counter reaches 1, then reloads a full bit period.
  assign tick = (cnt_q == CntW'(1));
  assign push = (state_q == StStop) && tick && rx_s && parity_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      if (state_q != StIdle && state_q != StBreak) begin
        cnt_q <= tick ? CntFull : cnt_q - CntW'(1);
      end
      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q   <= StStart;
            cnt_q     <= CntHalf;
            bit_cnt_q <= '0;
          end
        end
        StStart: begin
          if (tick) state_q <= rx_s ? StIdle : StData;
        end
        StData: begin
          if (tick) begin
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick) begin
            parity_q <= rx_s;
            state_q  <= StStop;
          end
        end
`endif
        StStop: begin
          if (tick) begin
            if (rx_s) begin
              // Good stop bit; a parity mismatch still discards the byte.
              frame_err_q <= ~parity_ok;
              state_q     <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end
          end
        end
        StBreak: begin
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Receive FIFO
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              overflow_q;
  logic              full, pop, do_push;
  logic [7:0]        head_byte;

  assign full     = (count_q == CountFull);
  assign rx_valid = (count_q != '0);
  assign pop      = uart_read_en && rx_valid;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push  = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !pop)      count_q <= count_q + CountW'(1);
      else if (pop && !do_push) count_q <= count_q - CountW'(1);
      if (pop)               overflow_q <= 1'b0;
      else if (push && full) overflow_q <= 1'b1;
    end
  end

  assign head_byte = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign rd_data   = {22'b0, overflow_q, rx_valid, head_byte};

endmodule
